mmio_timer: RTL and testbench

//  Memory-mapped 32-bit timer/compare peripheral that responds on the CPU data-memory port
//  (ena/wea/addr/dina/douta), alongside the data RAM.
//  The CPU core is the initiator and this block is a responder, with the same 1-cycle

---
 rtl/mmio_timer_if.sv | 29 ++
 rtl/mmio_timer.sv | 184 ++++++++++++++++++
 tb/tb_mmio_timer.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mmio_timer_if.sv
// CPU data-memory port bundle (ena/wea/addr/dina/douta) shared by the RAM and the timer.
// The CPU drives the master side; responders such as mmio_timer take the slave side.
interface mmio_timer_if #(
  parameter int unsigned ADDR_W = 10
) ();

  logic              ena;
  logic [3:0]        wea;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       dina;
  logic [31:0]       douta;

  modport master (
    output ena,
    output wea,
    output addr,
    output dina,
    input  douta
  );

  modport slave (
    input  ena,
    input  wea,
    input  addr,
    input  dina,
    output douta
  );

endinterface

// File: rtl/mmio_timer.sv
// Memory-mapped 32-bit timer/compare peripheral on the CPU data-memory port.
// Register map (addr[4:2]): 0 CTRL {IRQ_EN, AUTO_RELOAD, EN}, 1 COUNT, 2 COMPARE,
// 3 STATUS {MATCH, write-1-to-clear}, 4 PRESCALE[15:0], 5..7 unmapped.
// Reads have one cycle of registered latency and return the pre-update value.
// Optional feature macro: TIMER_PRESCALER_EN adds the PRESCALE register and prescale counter;
// without it the counter ticks every cycle while EN=1 and PRESCALE reads as 0.
module mmio_timer #(
  parameter int unsigned ADDR_W  = 10,
  parameter logic [31:0] CMP_RST = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  mmio_timer_if.slave bus,
  output logic        irq
);

  localparam logic [2:0] SelCtrl     = 3'd0;
  localparam logic [2:0] SelCount    = 3'd1;
  localparam logic [2:0] SelCompare  = 3'd2;
  localparam logic [2:0] SelStatus   = 3'd3;
  localparam logic [2:0] SelPrescale = 3'd4;

  // Merge the enabled bytes of wdata into cur.
  function automatic logic [31:0] byte_merge(input logic [31:0] cur,
                                             input logic [31:0] wdata,
                                             input logic [3:0]  be);
    logic [31:0] res;
    res = cur;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = wdata[8*i +: 8];
    end
    return res;
  endfunction

  // Bus decode
  logic [ADDR_W-1:0] addr;
  logic [2:0]        sel;
  logic              rd_en;
  logic              wr_en;
  logic              unused_addr;

  assign addr        = bus.addr;
  assign sel         = addr[4:2];
  assign unused_addr = ^{addr[ADDR_W-1:5], addr[1:0]};
  assign rd_en       = bus.ena && (bus.wea == 4'b0000);
  assign wr_en       = bus.ena && (bus.wea != 4'b0000);

  logic we_ctrl;
  logic we_count;
  logic we_compare;
  logic we_status;

  assign we_ctrl    = wr_en && (sel == SelCtrl);
  assign we_count   = wr_en && (sel == SelCount);
  assign we_compare = wr_en && (sel == SelCompare);
  assign we_status  = wr_en && (sel == SelStatus);

  // Architectural state
  logic [2:0]  ctrl_q, ctrl_d;
  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic        match_q, match_d;
  logic [31:0] douta_q, douta_d;

  logic        ctrl_en;
  logic        ctrl_reload;
  logic        ctrl_irq_en;

  assign ctrl_en     = ctrl_q[0];
  assign ctrl_reload = ctrl_q[1];
  assign ctrl_irq_en = ctrl_q[2];

  logic        tick;
  logic [15:0] prescale_rd;

`ifdef TIMER_PRESCALER_EN
  logic        we_prescale;
  logic [15:0] prescale_q, prescale_d;
  logic [15:0] pc_q, pc_d;
  logic [31:0] prescale_merged;

  assign we_prescale = wr_en && (sel == SelPrescale);
  assign tick        = ctrl_en && (pc_q == prescale_q);
  assign prescale_rd = prescale_q;

  // Prescale counter runs 0..PRESCALE and is held at 0 while the timer is disabled.
  always_comb begin
    pc_d = pc_q + 16'd1;
    if (!ctrl_en || tick) pc_d = 16'd0;
  end

  // PRESCALE byte writes (only the low two bytes exist).
  always_comb begin
    prescale_merged = byte_merge({16'd0, prescale_q}, bus.dina, {2'b00, bus.wea[1:0]});
    prescale_d      = prescale_q;
    if (we_prescale) prescale_d = prescale_merged[15:0];
  end

  // Prescaler state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescale_q <= 16'd0;
      pc_q       <= 16'd0;
    end else begin
      prescale_q <= prescale_d;
      pc_q       <= pc_d;
    end
  end
`else
  assign tick        = ctrl_en;
  assign prescale_rd = 16'd0;
`endif

  // Compare always uses the register value before this edge's write.
  logic hit;
  assign hit = tick && (count_q == compare_q);

  // CTRL: only byte 0 holds implemented bits.
  always_comb begin
    ctrl_d = ctrl_q;
    if (we_ctrl && bus.wea[0]) ctrl_d = bus.dina[2:0];
  end

  // COUNT: tick result first, then written bytes override it.
  always_comb begin
    logic [31:0] count_tick;
    count_tick = count_q;
    if (tick) begin
      if (hit && ctrl_reload) count_tick = 32'd0;
      else                    count_tick = count_q + 32'd1;
    end
    count_d = count_tick;
    if (we_count) count_d = byte_merge(count_tick, bus.dina, bus.wea);
  end

  // COMPARE byte writes.
  always_comb begin
    compare_d = compare_q;
    if (we_compare) compare_d = byte_merge(compare_q, bus.dina, bus.wea);
  end

  // MATCH: write-1-to-clear, a same-cycle match wins.
  always_comb begin
    match_d = match_q;
    if (we_status && bus.wea[0] && bus.dina[0]) match_d = 1'b0;
    if (hit) match_d = 1'b1;
  end

  // Read mux; douta only updates on read strobes.
  always_comb begin
    logic [31:0] rdata;
    case (sel)
      SelCtrl:     rdata = {29'd0, ctrl_q};
      SelCount:    rdata = count_q;
      SelCompare:  rdata = compare_q;
      SelStatus:   rdata = {31'd0, match_q};
      SelPrescale: rdata = {16'd0, prescale_rd};
      default:     rdata = 32'd0;
    endcase
    douta_d = douta_q;
    if (rd_en) douta_d = rdata;
  end

  // Timer and read-data registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q    <= 3'd0;
      count_q   <= 32'd0;
      compare_q <= CMP_RST;
      match_q   <= 1'b0;
      douta_q   <= 32'd0;
    end else begin
      ctrl_q    <= ctrl_d;
      count_q   <= count_d;
      compare_q <= compare_d;
      match_q   <= match_d;
      douta_q   <= douta_d;
    end
  end

  assign bus.douta = douta_q;
  assign irq       = match_q & ctrl_irq_en;

endmodule

// File: tb/tb_mmio_timer.sv
// Scoreboard bench for mmio_timer: reads push expected data, a monitor pops and compares
// one cycle after each read strobe.
`timescale 1ns/1ps
module tb_mmio_timer;

  localparam logic [9:0] ACtrl  = 10'h00;
  localparam logic [9:0] ACount = 10'h04;
  localparam logic [9:0] ACmp   = 10'h08;
  localparam logic [9:0] AStat  = 10'h0C;
  localparam logic [9:0] APre   = 10'h10;
  localparam logic [9:0] AUnm   = 10'h14;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic irq;
  logic rd_valid;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];
  string       name_q[$];

  mmio_timer_if #(.ADDR_W(10)) bus ();

  mmio_timer #(
    .ADDR_W (10),
    .CMP_RST(32'hFFFF_FFFF)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus),
    .irq  (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Bench-side read-valid: douta is due one edge after a read strobe; reset drops it.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_valid <= 1'b0;
    else        rd_valid <= bus.ena && (bus.wea == 4'b0000);
  end

  // Monitor: pop and compare whenever read data is presented.
  always @(negedge clk) begin
    if (rd_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_underflow: got %h expected none", bus.douta);
      end else begin
        logic [31:0] e;
        string       n;
        e = exp_q.pop_front();
        n = name_q.pop_front();
        check(n, bus.douta, e);
      end
    end
  end

  task automatic drive(input logic [9:0] a, input logic [3:0] we, input logic [31:0] d);
    @(negedge clk);
    bus.ena  = 1'b1;
    bus.wea  = we;
    bus.addr = a;
    bus.dina = d;
  endtask

  task automatic rd(input logic [9:0] a, input logic [31:0] e, input string n);
    drive(a, 4'h0, 32'h0);
    exp_q.push_back(e);
    name_q.push_back(n);
  endtask

  task automatic wr(input logic [9:0] a, input logic [31:0] d);
    drive(a, 4'hF, d);
  endtask

  task automatic idle();
    @(negedge clk);
    bus.ena = 1'b0;
    bus.wea = 4'h0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] t1 [8];
    logic [31:0] t3 [8];
    t1 = '{32'h0, 32'h0, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    t3 = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd0, 32'd1, 32'd2, 32'd3};

    bus.ena  = 1'b0;
    bus.wea  = 4'h0;
    bus.addr = 10'h0;
    bus.dina = 32'h0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_douta", bus.douta, 32'h0);
    check("rst_irq", {31'd0, irq}, 32'h0);
    rst_n = 1'b1;

    // Read every register after reset
    for (int i = 0; i < 8; i++) begin
      logic [9:0] a;
      a = 10'(i * 4);
      rd(a, t1[i], $sformatf("reset_rd_%0d", i));
    end

    // douta holds over write and idle cycles; unmapped writes ignored
    rd(ACmp, 32'hFFFF_FFFF, "cmp_before_hold");
    wr(AUnm, 32'h1234_5678);
    idle();
    idle();
    check("douta_hold", bus.douta, 32'hFFFF_FFFF);
    rd(AUnm, 32'h0, "unmapped_rd");

    // Byte write to COMPARE
    drive(ACmp, 4'b0010, 32'h0000_AB00);
    rd(ACmp, 32'hFFFF_ABFF, "cmp_byte_wr");

    // CTRL unimplemented bits read 0
    wr(ACtrl, 32'hFFFF_FFF8);
    rd(ACtrl, 32'h0, "ctrl_upper_bits");

    // PRESCALE visibility depends on the build
    wr(APre, 32'hABCD_1234);
`ifdef TIMER_PRESCALER_EN
    rd(APre, 32'h0000_1234, "prescale_rd");
`else
    rd(APre, 32'h0, "prescale_rd");
`endif
    wr(APre, 32'h0);

    // COUNT byte write on a tick edge: byte 0 from CPU, rest from tick result
    wr(ACount, 32'h0000_01FF);
    wr(ACtrl, 32'h1);
    drive(ACount, 4'b0001, 32'h0000_0011);
    rd(ACount, 32'h0000_0211, "count_wr_on_tick");
    rd(ACount, 32'h0000_0212, "count_after_merge");
    wr(ACtrl, 32'h0);

    // Free-running count with compare at 5
    wr(ACount, 32'h0);
    wr(ACmp, 32'd5);
    wr(ACtrl, 32'h1);
    for (int k = 0; k < 8; k++) rd(ACount, 32'(k), $sformatf("free_count_%0d", k));
    rd(AStat, 32'h1, "match_set");
    wr(ACtrl, 32'h5);
    check("irq_gated", {31'd0, irq}, 32'h0);
    idle();
    check("irq_enabled", {31'd0, irq}, 32'h1);
    wr(ACtrl, 32'h0);
    wr(ACount, 32'h0);
    wr(AStat, 32'h1);
    idle();
    check("irq_cleared", {31'd0, irq}, 32'h0);

    // Auto-reload with compare at 3; W1C collides with a new match on the 4th edge
    wr(ACmp, 32'd3);
    wr(ACtrl, 32'h7);
    for (int k = 0; k < 8; k++) rd(ACount, t3[k], $sformatf("reload_count_%0d", k));
    rd(AStat, 32'h1, "reload_match");
    rd(AStat, 32'h1, "reload_match_b");
    check("reload_irq", {31'd0, irq}, 32'h1);
    rd(AStat, 32'h1, "reload_match_c");
    drive(AStat, 4'h1, 32'h1);
    rd(AStat, 32'h1, "w1c_vs_set");
    drive(AStat, 4'h1, 32'h1);
    rd(AStat, 32'h0, "w1c_clear");
    check("irq_drop", {31'd0, irq}, 32'h0);
    wr(ACtrl, 32'h0);
    wr(AStat, 32'h1);
    wr(ACount, 32'h0);

`ifdef TIMER_PRESCALER_EN
    // Prescale of 2: one increment every 3 cycles
    wr(ACmp, 32'd100);
    wr(APre, 32'd2);
    wr(ACtrl, 32'h1);
    rd(ACount, 32'd0, "pre_0");
    rd(ACount, 32'd0, "pre_1");
    rd(ACount, 32'd0, "pre_2");
    rd(ACount, 32'd1, "pre_3");
    rd(ACount, 32'd1, "pre_4");
    rd(ACount, 32'd1, "pre_5");
    rd(ACount, 32'd2, "pre_6");
    wr(ACtrl, 32'h0);
    wr(APre, 32'h0);
    wr(ACount, 32'h0);
`endif

    // Asynchronous reset in the middle of a read with irq high
    wr(ACmp, 32'd2);
    wr(ACtrl, 32'h7);
    repeat (4) idle();
    drive(ACmp, 4'h0, 32'h0);
    @(posedge clk);
    #1;
    check("pre_rst_douta", bus.douta, 32'd2);
    check("pre_rst_irq", {31'd0, irq}, 32'h1);
    rst_n   = 1'b0;
    bus.ena = 1'b0;
    #1;
    check("async_rst_douta", bus.douta, 32'h0);
    check("async_rst_irq", {31'd0, irq}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    rd(ACount, 32'h0, "post_rst_count");
    rd(ACtrl, 32'h0, "post_rst_ctrl");
    rd(ACmp, 32'hFFFF_FFFF, "post_rst_cmp");
    rd(AStat, 32'h0, "post_rst_status");
    idle();

    // Drain the scoreboard within a bounded number of cycles
    for (int c = 0; c < 20 && exp_q.size() != 0; c++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d pending expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
